// File: rtl/act_pkg.sv
// Shared types and constants for the act_pipe activation stage.
package act_pkg;

  // Activation selected per beat; encoding matches the in_mode/out_mode field.
  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

  // 6.0 in Q8.8, the conventional ReLU6 bound.
  localparam logic [15:0] ACT_CAP_DEFAULT = 16'h0600;

endpackage

// File: rtl/act_pipe_if.sv
// Beat-level handshake bundle for act_pipe: input side (val/rdy/mode/cap/data)
// and output side (val/rdy/mode/data). The DUT takes the slave view.
interface act_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic                     in_val;
  logic                     in_rdy;
  logic [1:0]               in_mode;
  logic [WIDTH-1:0]         in_cap;
  logic [LANES*WIDTH-1:0]   in_data;
  logic                     out_val;
  logic                     out_rdy;
  logic [LANES*WIDTH-1:0]   out_data;
  logic [1:0]               out_mode;

  modport master (
    output in_val, in_mode, in_cap, in_data, out_rdy,
    input  in_rdy, out_val, out_data, out_mode
  );

  modport slave (
    input  in_val, in_mode, in_cap, in_data, out_rdy,
    output in_rdy, out_val, out_data, out_mode
  );
endinterface

// File: rtl/act_lane.sv
// One lane of the activation function (purely combinational).
// clipped is set whenever a non-PASS mode changed the value.
module act_lane
  import act_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] x,
  input  act_mode_e               mode,
  input  logic [WIDTH-1:0]        cap,
  output logic [WIDTH-1:0]        y,
  output logic                    clipped
);

  logic signed [WIDTH-1:0] cap_eff_s;
  logic signed [WIDTH-1:0] y_s;

  // Apply the selected activation; a cap with its sign bit set acts as zero.
  always_comb begin
    cap_eff_s = cap[WIDTH-1] ? '0 : $signed(cap);
    y_s       = x;
    case (mode)
      ACT_PASS:  y_s = x;
      ACT_RELU:  y_s = x[WIDTH-1] ? '0 : x;
      ACT_LEAKY: y_s = x[WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
      ACT_CLAMP: y_s = x[WIDTH-1] ? '0 : ((x > cap_eff_s) ? cap_eff_s : x);
      default:   y_s = x;
    endcase
  end

  assign y       = y_s;
  assign clipped = (mode != ACT_PASS) && (y_s != x);

endmodule

// File: rtl/act_pipe.sv
// act_pipe: two-stage, multi-lane activation stage with valid/ready on both
// sides. S1 holds the raw beat, S2 holds the activated result and drives out_*.
// Optional clip statistics counter enabled by defining ACT_PIPE_STATS_EN.
module act_pipe
  import act_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  act_pipe_if.slave   bus
`ifdef ACT_PIPE_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_clip_cnt
`endif
);

  // S1 cap resets to the format's default clamp (6.0 in fixed point).
  localparam logic [WIDTH-1:0] CAP_DEFAULT = WIDTH'(32'd6 << FRAC);

  logic                   s1_val_r;
  logic [LANES*WIDTH-1:0] s1_data_r;
  act_mode_e              s1_mode_r;
  logic [WIDTH-1:0]       s1_cap_r;
  logic                   s2_val_r;
  logic [LANES*WIDTH-1:0] s2_data_r;
  act_mode_e              s2_mode_r;
  logic                   s1_adv_s;
  logic                   s2_adv_s;
  logic [LANES*WIDTH-1:0] lane_y_s;
  logic [LANES-1:0]       lane_clip_s;

  assign s2_adv_s = !s2_val_r || bus.out_rdy;
  assign s1_adv_s = !s1_val_r || s2_adv_s;
  assign bus.in_rdy   = s1_adv_s;
  assign bus.out_val  = s2_val_r;
  assign bus.out_data = s2_data_r;
  assign bus.out_mode = s2_mode_r;

  // S1: capture the raw beat whenever the stage can move forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val_r  <= 1'b0;
      s1_data_r <= '0;
      s1_mode_r <= ACT_PASS;
      s1_cap_r  <= CAP_DEFAULT;
    end else if (s1_adv_s) begin
      s1_val_r <= bus.in_val;
      if (bus.in_val) begin
        s1_data_r <= bus.in_data;
        s1_mode_r <= act_mode_e'(bus.in_mode);
        s1_cap_r  <= bus.in_cap;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x       (s1_data_r[g*WIDTH +: WIDTH]),
      .mode    (s1_mode_r),
      .cap     (s1_cap_r),
      .y       (lane_y_s[g*WIDTH +: WIDTH]),
      .clipped (lane_clip_s[g])
    );
  end

  // S2: register the activated beat; holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_val_r  <= 1'b0;
      s2_data_r <= '0;
      s2_mode_r <= ACT_PASS;
    end else if (s2_adv_s) begin
      s2_val_r <= s1_val_r;
      if (s1_val_r) begin
        s2_data_r <= lane_y_s;
        s2_mode_r <= s1_mode_r;
      end
    end
  end

`ifdef ACT_PIPE_STATS_EN
  localparam int CLIP_W = $clog2(LANES + 1);

  logic [CLIP_W-1:0] s2_clip_r;
  logic [31:0]       stat_cnt_r;
  logic [32:0]       clip_sum_s;

  function automatic logic [CLIP_W-1:0] count_clips(input logic [LANES-1:0] f);
    logic [CLIP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + CLIP_W'(f[i]);
    end
    return n;
  endfunction

  // Per-beat clipped-lane count travels alongside the S2 data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_clip_r <= '0;
    end else if (s2_adv_s && s1_val_r) begin
      s2_clip_r <= count_clips(lane_clip_s);
    end
  end

  assign clip_sum_s = {1'b0, stat_cnt_r} + 33'(s2_clip_r);

  // Saturating clip counter, bumped at each output handshake; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt_r <= 32'd0;
    end else if (stat_clr) begin
      stat_cnt_r <= 32'd0;
    end else if (s2_val_r && bus.out_rdy) begin
      stat_cnt_r <= clip_sum_s[32] ? 32'hFFFF_FFFF : clip_sum_s[31:0];
    end
  end

  assign stat_clip_cnt = stat_cnt_r;
`else
  logic unused_clip_s;
  assign unused_clip_s = ^lane_clip_s;
`endif

endmodule

// File: tb/tb_act_pipe.sv
// Directed + scoreboard bench for act_pipe (Q8.8, 4 lanes, LEAK_SHIFT 3).
// Define ACT_PIPE_STATS_EN to include the clip-counter scenario.
module tb_act_pipe;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  act_pipe_if #(.WIDTH(16), .LANES(4)) bus ();

`ifdef ACT_PIPE_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_clip_cnt;
`endif

  act_pipe #(
    .WIDTH      (16),
    .FRAC       (8),
    .LANES      (4),
    .LEAK_SHIFT (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef ACT_PIPE_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_clip_cnt (stat_clip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Reference lane: integer arithmetic, leaky as floor division by 8.
  function automatic logic [15:0] ref_lane(input logic [15:0] xb, input logic [1:0] m,
                                           input logic [15:0] cb);
    int v;
    int c;
    int r;
    v = int'($signed(xb));
    c = cb[15] ? 0 : int'(cb);
    case (m)
      2'd0:    r = v;
      2'd1:    r = (v < 0) ? 0 : v;
      2'd2:    r = (v < 0) ? -((-v + 7) / 8) : v;
      default: r = (v < 0) ? 0 : ((v > c) ? c : v);
    endcase
    return r[15:0];
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'h0000;
      3:       return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_val = 1'b0; bus.in_mode = 2'd0; bus.in_cap = 16'h0000; bus.in_data = 64'd0;
    bus.out_rdy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL reset_out_val got %b want 0", bus.out_val); end
    n_vec++;
    if (bus.out_data !== 64'd0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_vec++;
    if (bus.out_mode !== 2'd0) begin n_err++; $display("FAIL reset_out_mode got %0d want 0", bus.out_mode); end
    n_vec++;
    if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy got %b want 1", bus.in_rdy); end
    tick();
  endtask

  // Back-to-back beats with a different mode each, checking exact latency.
  task automatic test_modes();
    logic [63:0] dv [6];
    logic [63:0] ev [6];
    logic [1:0]  mv [6];
    logic [15:0] cv [6];
    dv[0] = pk(16'h0100, 16'hff00, 16'h0700, 16'h8000); mv[0] = 2'd0; cv[0] = 16'h0050;
    ev[0] = pk(16'h0100, 16'hff00, 16'h0700, 16'h8000);
    dv[1] = dv[0]; mv[1] = 2'd1; cv[1] = 16'h0050;
    ev[1] = pk(16'h0100, 16'h0000, 16'h0700, 16'h0000);
    dv[2] = dv[0]; mv[2] = 2'd2; cv[2] = 16'h0050;
    ev[2] = pk(16'h0100, 16'hffe0, 16'h0700, 16'hf000);
    dv[3] = dv[0]; mv[3] = 2'd3; cv[3] = 16'h0600;
    ev[3] = pk(16'h0100, 16'h0000, 16'h0600, 16'h0000);
    dv[4] = pk(16'h0700, 16'h0000, 16'h7fff, 16'h0001); mv[4] = 2'd3; cv[4] = 16'h0700;
    ev[4] = pk(16'h0700, 16'h0000, 16'h0700, 16'h0001);
    dv[5] = pk(16'hffff, 16'hfff8, 16'hfff9, 16'h0000); mv[5] = 2'd2; cv[5] = 16'h8000;
    ev[5] = pk(16'hffff, 16'hffff, 16'hffff, 16'h0000);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        bus.in_val = 1'b1; bus.in_data = dv[i]; bus.in_mode = mv[i]; bus.in_cap = cv[i];
      end else begin
        bus.in_val = 1'b0;
      end
      #1;
      n_vec++;
      if (i >= 2) begin
        if (bus.out_val !== 1'b1 || bus.out_data !== ev[i-2] || bus.out_mode !== mv[i-2]) begin
          n_err++;
          $display("FAIL modes[%0d] got val=%b data=%h mode=%0d want val=1 data=%h mode=%0d",
                   i - 2, bus.out_val, bus.out_data, bus.out_mode, ev[i-2], mv[i-2]);
        end
      end else if (bus.out_val !== 1'b0) begin
        n_err++;
        $display("FAIL modes_latency cycle %0d got out_val=%b want 0", i, bus.out_val);
      end
      tick();
    end
    #1;
    n_vec++;
    if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL modes_tail got out_val=%b want 0", bus.out_val); end
    tick();
  endtask

  // Eight PASS beats with out_rdy low for cycles 3..6.
  task automatic test_backpressure();
    int          sent;
    int          got;
    logic        held_v;
    logic [63:0] held_d;
    logic        saw_low;
    logic        acc;
    logic [63:0] exp_d;
    sent = 0; got = 0; held_v = 1'b0; held_d = 64'd0; saw_low = 1'b0;
    bus.in_val = 1'b1; bus.in_mode = 2'd0; bus.in_cap = 16'h0000;
    bus.in_data = pk(16'h0000, 16'h0001, 16'h0002, 16'h0003);
    for (int c = 0; c < 40; c++) begin
      bus.out_rdy = !(c >= 3 && c <= 6);
      #1;
      if (held_v) begin
        n_vec++;
        if (bus.out_val !== 1'b1 || bus.out_data !== held_d) begin
          n_err++;
          $display("FAIL bp_hold got val=%b data=%h want val=1 data=%h", bus.out_val, bus.out_data, held_d);
        end
      end
      if (!bus.in_rdy) saw_low = 1'b1;
      if (bus.out_val && bus.out_rdy) begin
        exp_d = pk(16'(got * 256), 16'(got * 256 + 1), 16'(got * 256 + 2), 16'(got * 256 + 3));
        n_vec++;
        if (got >= 8 || bus.out_data !== exp_d) begin
          n_err++;
          $display("FAIL bp_beat[%0d] got %h want %h", got, bus.out_data, exp_d);
        end
        got++;
      end
      held_v = bus.out_val && !bus.out_rdy;
      held_d = bus.out_data;
      acc = bus.in_val && bus.in_rdy;
      tick();
      if (acc) begin
        sent++;
        if (sent < 8) begin
          bus.in_data = pk(16'(sent * 256), 16'(sent * 256 + 1), 16'(sent * 256 + 2), 16'(sent * 256 + 3));
        end else begin
          bus.in_val = 1'b0;
        end
      end
    end
    n_vec++;
    if (got != 8) begin n_err++; $display("FAIL bp_count got %0d beats want 8", got); end
    n_vec++;
    if (saw_low !== 1'b1) begin n_err++; $display("FAIL bp_in_rdy_drop got %b want 1", saw_low); end
    n_vec++;
    if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL bp_idle got out_val=%b want 0", bus.out_val); end
  endtask

  // Random beats against the integer reference model, random backpressure.
  task automatic test_soak();
    logic [63:0] eq_d [$];
    logic [1:0]  eq_m [$];
    logic [63:0] e;
    logic [1:0]  em;
    logic        acc;
    int          sent;
    int          got;
    int          cyc;
    sent = 0; got = 0; cyc = 0;
    bus.in_val = 1'b0;
    while (got < 10000 && cyc < 60000) begin
      if (!bus.in_val && sent < 10000) begin
        bus.in_val = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < 4; j++) bus.in_data[j*16 +: 16] = rand_lane();
        bus.in_mode = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       bus.in_cap = 16'($urandom) | 16'h8000;
          1:       bus.in_cap = bus.in_data[15:0];
          default: bus.in_cap = 16'($urandom) & 16'h7fff;
        endcase
      end
      bus.out_rdy = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_val && bus.out_rdy) begin
        n_vec++;
        if (eq_d.size() == 0) begin
          n_err++;
          $display("FAIL soak_extra unexpected beat data=%h", bus.out_data);
        end else begin
          e = eq_d.pop_front();
          em = eq_m.pop_front();
          if (bus.out_data !== e || bus.out_mode !== em) begin
            n_err++;
            $display("FAIL soak[%0d] got data=%h mode=%0d want data=%h mode=%0d",
                     got, bus.out_data, bus.out_mode, e, em);
          end
        end
        got++;
      end
      acc = bus.in_val && bus.in_rdy;
      if (acc) begin
        for (int j = 0; j < 4; j++) e[j*16 +: 16] = ref_lane(bus.in_data[j*16 +: 16], bus.in_mode, bus.in_cap);
        eq_d.push_back(e);
        eq_m.push_back(bus.in_mode);
        sent++;
      end
      tick();
      cyc++;
      if (acc) bus.in_val = 1'b0;
    end
    n_vec++;
    if (got != 10000) begin n_err++; $display("FAIL soak_timeout got %0d beats want 10000", got); end
  endtask

  // Reset with two beats in flight, then confirm clean restart latency.
  task automatic test_reset_mid();
    bus.out_rdy = 1'b0; bus.in_mode = 2'd1; bus.in_cap = 16'h0000;
    bus.in_val = 1'b1; bus.in_data = pk(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick();
    bus.in_data = pk(16'h5555, 16'h6666, 16'h7777, 16'h0888);
    tick();
    bus.in_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL rstmid_flush cycle %0d got out_val=%b want 0", i, bus.out_val); end
      tick();
    end
    bus.in_val = 1'b1; bus.in_mode = 2'd2; bus.in_data = pk(16'hff00, 16'h0042, 16'h8000, 16'h0000);
    tick();
    bus.in_val = 1'b0;
    #1;
    n_vec++;
    if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL rstmid_early got out_val=%b want 0", bus.out_val); end
    tick();
    n_vec++;
    if (bus.out_val !== 1'b1 || bus.out_data !== pk(16'hffe0, 16'h0042, 16'hf000, 16'h0000)) begin
      n_err++;
      $display("FAIL rstmid_beat got val=%b data=%h want val=1 data=%h",
               bus.out_val, bus.out_data, pk(16'hffe0, 16'h0042, 16'hf000, 16'h0000));
    end
    tick();
  endtask

`ifdef ACT_PIPE_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_rdy = 1'b1; bus.in_mode = 2'd1; bus.in_cap = 16'h0000;
    bus.in_data = pk(16'hffff, 16'h0005, 16'hfed4, 16'h0007);
    bus.in_val = 1'b1;
    repeat (3) tick();
    bus.in_val = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (stat_clip_cnt !== 32'd6) begin n_err++; $display("FAIL stats_count got %0d want 6", stat_clip_cnt); end
    bus.in_val = 1'b1;
    tick();
    bus.in_val = 1'b0;
    tick();
    stat_clr = 1'b1;
    #1;
    n_vec++;
    if (bus.out_val !== 1'b1 || stat_clip_cnt !== 32'd6) begin
      n_err++;
      $display("FAIL stats_pre_clr got val=%b cnt=%0d want val=1 cnt=6", bus.out_val, stat_clip_cnt);
    end
    tick();
    stat_clr = 1'b0;
    n_vec++;
    if (stat_clip_cnt !== 32'd0) begin n_err++; $display("FAIL stats_clr_wins got %0d want 0", stat_clip_cnt); end
    tick();
    n_vec++;
    if (stat_clip_cnt !== 32'd0) begin n_err++; $display("FAIL stats_after_clr got %0d want 0", stat_clip_cnt); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef ACT_PIPE_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_modes();
    test_backpressure();
    test_soak();
    test_reset_mid();
`ifdef ACT_PIPE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
